// File: rtl/regfile_pkg.sv
// Shared constants and port-slice helper for the multi-port register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Low bit of port k's field in a flattened per-port bus of fields 'width' wide.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending flags: writeback clears, issue sets, and issue wins a same-cycle tie.
module regfile_scoreboard #(
  parameter int ADDR_W   = regfile_pkg::DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wen0,
  input  logic [ADDR_W-1:0]      waddr0,
  input  logic                   wen1,
  input  logic [ADDR_W-1:0]      waddr1,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic [(2**ADDR_W)-1:0] pend_nxt,
  output logic [(2**ADDR_W)-1:0] pend_vec
);
  always_comb begin
    pend_nxt = pend_vec;
    if (wen0) pend_nxt[waddr0] = 1'b0;
    if (wen1) pend_nxt[waddr1] = 1'b0;
    if (issue_valid) pend_nxt[issue_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_vec <= '0;
    else       pend_vec <= pend_nxt;
  end
endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with write-first registered reads and issue scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wen0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       wen1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          ren,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rpend,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic [(2**ADDR_W)-1:0]     pend_vec
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             pend_nxt;

  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .wen0        (wen0),
    .waddr0      (waddr0),
    .wen1        (wen1),
    .waddr1      (waddr1),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .pend_nxt    (pend_nxt),
    .pend_vec    (pend_vec)
  );

  // Port 1 overrides port 0 on an address collision; r0 stays zero when hardwired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG != 0 && i == 0)                mem[i] <= '0;
        else if (wen1 && waddr1 == ADDR_W'(i))      mem[i] <= wdata1;
        else if (wen0 && waddr0 == ADDR_W'(i))      mem[i] <= wdata0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] byp;
    logic [DATA_W-1:0] rd_q;
    logic              rp_q;

    assign ra = raddr[slice_lo(k, ADDR_W) +: ADDR_W];

    // Same-edge write data is forwarded so the read sees post-edge contents.
    always_comb begin
      if (ZERO_REG != 0 && ra == '0)   byp = '0;
      else if (wen1 && waddr1 == ra)   byp = wdata1;
      else if (wen0 && waddr0 == ra)   byp = wdata0;
      else                             byp = mem[ra];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q <= '0;
        rp_q <= 1'b0;
      end else if (ren[k]) begin
        rd_q <= byp;
        rp_q <= pend_nxt[ra];
      end
    end

    assign rdata[slice_lo(k, DATA_W) +: DATA_W] = rd_q;
    assign rpend[k] = rp_q;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp with default parameters (32x32, 2 read ports, hardwired r0).
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           wen0, wen1, issue_valid;
  logic [AW-1:0]  waddr0, waddr1, issue_addr;
  logic [DW-1:0]  wdata0, wdata1;
  logic [NR-1:0]  ren;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rpend;
  logic [31:0]    pend_vec;

  int n_vec = 0;
  int n_bad = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    ren = '0; raddr = '0; issue_valid = 0; issue_addr = '0;
  endtask

  // Drive at negedge, let one rising edge pass, sample 1 time unit later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_vec++; if (rpend !== '0) begin n_bad++; $display("FAIL reset_rpend got %b want 0", rpend); end
    n_vec++; if (pend_vec !== '0) begin n_bad++; $display("FAIL reset_pend_vec got %h want 0", pend_vec); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); idle(); wen0 = 1; waddr0 = AW'(i); wdata0 = DW'(i);
      step();
    end
    @(negedge clk); idle(); ren = 2'b11; raddr = {5'd1, 5'd0};
    step();
    n_vec++; if (rdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL fill_r0 got %h want 0", rdata[31:0]); end
    n_vec++; if (rdata[63:32] !== 32'd1) begin n_bad++; $display("FAIL fill_r1 got %h want 1", rdata[63:32]); end
    @(negedge clk); idle(); ren = 2'b01; raddr = {5'd2, 5'd31};
    step();
    n_vec++; if (rdata[31:0] !== 32'd31) begin n_bad++; $display("FAIL fill_r31 got %h want 1f", rdata[31:0]); end
    n_vec++; if (rdata[63:32] !== 32'd1) begin n_bad++; $display("FAIL hold_port1 got %h want 1", rdata[63:32]); end
  endtask

  task automatic test_collision();
    @(negedge clk); idle();
    wen0 = 1; waddr0 = 5'd8; wdata0 = 32'hAAAA_AAAA;
    wen1 = 1; waddr1 = 5'd8; wdata1 = 32'h5555_5555;
    step();
    @(negedge clk); idle(); ren = 2'b10; raddr = {5'd8, 5'd0};
    step();
    n_vec++; if (rdata[63:32] !== 32'h5555_5555) begin n_bad++; $display("FAIL collision_r8 got %h want 55555555", rdata[63:32]); end
    // Port 0 alone to a different address on the same edge as port 1 must still land.
    @(negedge clk); idle();
    wen0 = 1; waddr0 = 5'd9; wdata0 = 32'h0000_0A09;
    wen1 = 1; waddr1 = 5'd20; wdata1 = 32'h0000_0B14;
    step();
    @(negedge clk); idle(); ren = 2'b11; raddr = {5'd20, 5'd9};
    step();
    n_vec++; if (rdata[31:0] !== 32'h0000_0A09) begin n_bad++; $display("FAIL dual_write_r9 got %h want 00000a09", rdata[31:0]); end
    n_vec++; if (rdata[63:32] !== 32'h0000_0B14) begin n_bad++; $display("FAIL dual_write_r20 got %h want 00000b14", rdata[63:32]); end
  endtask

  task automatic test_bypass();
    @(negedge clk); idle();
    wen0 = 1; waddr0 = 5'd17; wdata0 = 32'h39CE_7F9E;
    ren = 2'b01; raddr = {5'd0, 5'd17};
    step();
    n_vec++; if (rdata[31:0] !== 32'h39CE_7F9E) begin n_bad++; $display("FAIL bypass_p0 got %h want 39ce7f9e", rdata[31:0]); end
    @(negedge clk); idle();
    wen1 = 1; waddr1 = 5'd17; wdata1 = 32'h1234_5678;
    ren = 2'b10; raddr = {5'd17, 5'd0};
    step();
    n_vec++; if (rdata[63:32] !== 32'h1234_5678) begin n_bad++; $display("FAIL bypass_p1 got %h want 12345678", rdata[63:32]); end
  endtask

  task automatic test_zero();
    @(negedge clk); idle();
    wen0 = 1; waddr0 = 5'd0; wdata0 = 32'hC010_0420;
    issue_valid = 1; issue_addr = 5'd0;
    ren = 2'b01; raddr = {5'd0, 5'd0};
    step();
    n_vec++; if (rdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL zero_bypass got %h want 0", rdata[31:0]); end
    n_vec++; if (pend_vec[0] !== 1'b0) begin n_bad++; $display("FAIL zero_pend got %b want 0", pend_vec[0]); end
    n_vec++; if (rpend[0] !== 1'b0) begin n_bad++; $display("FAIL zero_rpend got %b want 0", rpend[0]); end
    @(negedge clk); idle(); ren = 2'b10; raddr = {5'd0, 5'd0};
    step();
    n_vec++; if (rdata[63:32] !== 32'd0) begin n_bad++; $display("FAIL zero_stored got %h want 0", rdata[63:32]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk); idle(); issue_valid = 1; issue_addr = 5'd10;
    step();
    n_vec++; if (pend_vec !== 32'h0000_0400) begin n_bad++; $display("FAIL issue_r10 got %h want 00000400", pend_vec); end
    @(negedge clk); idle(); ren = 2'b01; raddr = {5'd0, 5'd10};
    step();
    n_vec++; if (rpend !== 2'b01) begin n_bad++; $display("FAIL rpend_r10 got %b want 01", rpend); end
    @(negedge clk); idle(); wen1 = 1; waddr1 = 5'd10; wdata1 = 32'hA;
    ren = 2'b01; raddr = {5'd0, 5'd10};
    step();
    n_vec++; if (pend_vec[10] !== 1'b0) begin n_bad++; $display("FAIL clear_r10 got %b want 0", pend_vec[10]); end
    n_vec++; if (rpend[0] !== 1'b0) begin n_bad++; $display("FAIL clear_rpend got %b want 0", rpend[0]); end
    @(negedge clk); idle(); issue_valid = 1; issue_addr = 5'd10;
    wen0 = 1; waddr0 = 5'd10; wdata0 = 32'hB;
    step();
    n_vec++; if (pend_vec[10] !== 1'b1) begin n_bad++; $display("FAIL set_wins got %b want 1", pend_vec[10]); end
    // Issue and read the same register on one edge: read sees post-edge pending state.
    @(negedge clk); idle(); issue_valid = 1; issue_addr = 5'd12;
    ren = 2'b10; raddr = {5'd12, 5'd0};
    step();
    n_vec++; if (rpend[1] !== 1'b1) begin n_bad++; $display("FAIL rpend_same_edge got %b want 1", rpend[1]); end
    n_vec++; if (pend_vec !== 32'h0000_1400) begin n_bad++; $display("FAIL pend_two got %h want 00001400", pend_vec); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle(); ren = 2'b11; raddr = {5'd10, 5'd31};
    step();
    @(negedge clk); idle();
    wen1 = 1; waddr1 = 5'd5; wdata1 = 32'hDEAD_BEEF;
    #2 reset = 1;
    #1;
    n_vec++; if (rdata !== '0) begin n_bad++; $display("FAIL async_rdata got %h want 0", rdata); end
    n_vec++; if (rpend !== '0) begin n_bad++; $display("FAIL async_rpend got %b want 0", rpend); end
    n_vec++; if (pend_vec !== '0) begin n_bad++; $display("FAIL async_pend got %h want 0", pend_vec); end
    @(posedge clk);
    @(negedge clk); reset = 0; idle(); ren = 2'b11; raddr = {5'd31, 5'd5};
    step();
    n_vec++; if (rdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL async_r5 got %h want 0", rdata[31:0]); end
    n_vec++; if (rdata[63:32] !== 32'd0) begin n_bad++; $display("FAIL async_r31 got %h want 0", rdata[63:32]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_collision();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file replacing the single-write, two-read unclocked register file in the datapath. It provides a configurable width, depth and read-port count, two clocked write ports with fixed priority, registered reads with write-first bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard for the issue stage. It sits between decode/issue (read and issue side) and writeback (write side).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never pending

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all registers, pending bits and read outputs
- wen0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- wen1  in  1  write enable, port 1 (priority port)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- ren  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W]
- rpend  out  NUM_RD  registered pending flag of the register read on port k
- issue_valid  in  1  marks issue_addr as pending (producer issued)
- issue_addr  in  ADDR_W  destination register being issued
- pend_vec  out  DEPTH  current pending bits, bit i = register i

## Operation
- Write: on a rising edge with wenX=1, reg[waddrX] <= wdataX.
- Same address on both ports in one cycle: port 1 data is stored; port 0 is dropped.
- ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0; pend_vec[0] is always 0.
- Read: on a rising edge with ren[k]=1, rdata[k] <= the value of reg[raddr[k]] as it stands after this edge's writes (write-first bypass, port-1 priority applied); rpend[k] <= post-edge pending bit. With ren[k]=0, rdata[k] and rpend[k] hold.
- Scoreboard, per edge: a write on either port to address a clears pend[a]; issue_valid sets pend[issue_addr]. A set and a clear to the same address in the same cycle leave the bit set (the new producer wins).
- pend_vec is the registered pending state, driven directly from flops.
- Reset is legal at any time, including mid-write. It forces all registers, pend_vec, rdata and rpend to 0 immediately. The first rising edge after deassertion behaves normally.

## Timing
- Write-to-storage: 1 edge. Read latency: 1 edge, with same-edge write data visible on the read output (bypass).
- Issue-to-pend_vec: 1 edge. Writeback-clear-to-pend_vec: 1 edge.
- All outputs are flop outputs; there is no combinational path from any input to any output.
- Reset values: rdata = 0, rpend = 0, pend_vec = 0, all storage = 0.

## Structure
- Shared package regfile_pkg holds the default DATA_W/ADDR_W constants and the port-slice helper function (address and data slicing).
- Natural sub-module: regfile_scoreboard, holding the DEPTH pending flops with their set/clear/priority logic and the pend_vec output.
- The storage array, write priority, bypass mux and read registers live in regfile_mp, generated per read port.

## Test plan
- Reset then fill: write reg i = i for i=1..31 via port 0, then read r0/r1 on two ports -> rdata = 0 and 1 one edge later; r31 -> 31.
- Port collision: wen0 and wen1 both target r8 in one cycle, with wdata0=0xAAAA_AAAA and wdata1=0x5555_5555 -> r8 reads 0x5555_5555.
- Bypass: write r17 = 0x39CE_7F9E while reading r17 on the same edge -> rdata = 0x39CE_7F9E after that edge, not the old value.
- Zero register: write r0 = 0xC010_0420 and issue r0 -> r0 reads 0 and pend_vec[0] stays 0.
- Scoreboard: issue r10 -> pend_vec[10]=1 and reading r10 gives rpend=1. A later write to r10 clears it. Issue r10 and write r10 in the same cycle -> pend_vec[10] stays 1.
- Async reset mid-operation: assert reset between edges while wen1=1 -> all outputs read 0 immediately without a clock edge, and the write is not retained.
